// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Round-robin arbiter that shares one combinational ALU between
//                two requesters. One operation every three cycles:
//                IDLE (accept) -> EXEC (drive ALU, capture) -> DONE (respond).
//
//  Ports
//    clk, reset                   clock; asynchronous active-high reset
//    reqN_valid / reqN_ready      per-requester handshake (N = 0, 1)
//    reqN_opcode, reqN_alu_op     per-requester ALU control fields
//    reqN_a, reqN_b               per-requester operands
//    alu_opcode, alu_op           registered control to the shared ALU
//    alu_a, alu_b                 registered operands to the shared ALU
//    alu_result, alu_zero         combinational ALU outputs
//    rsp_valid                    one-cycle response strobe
//    rsp_id, rsp_result, rsp_zero owning requester and captured ALU outputs
//    busy                         high whenever not in IDLE
//
//  Revision    : 1.0  initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [10:0]      req0_opcode,
    input  logic [10:0]      req1_opcode,
    input  logic [1:0]       req0_alu_op,
    input  logic [1:0]       req1_alu_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic [10:0]      alu_opcode,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic               last_q,    last_d;     // requester granted most recently
    logic               id_q,      id_d;       // owner of the in-flight operation
    logic [10:0]        opcode_q,  opcode_d;
    logic [1:0]         op_q,      op_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic               zero_q,    zero_d;
    logic               rsp_id_q,  rsp_id_d;

    logic               w_grant_id;
    logic               w_can_accept;
    logic               w_accept;

    always_comb begin
        // Contention goes to the requester not granted last; otherwise to
        // whichever one is asking (value is irrelevant when neither asks).
        w_grant_id   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        // Gating with reset keeps ready low for the whole reset assertion,
        // not merely from the next edge.
        w_can_accept = (state_q == IDLE) && !reset;
        req0_ready   = w_can_accept && req0_valid && !w_grant_id;
        req1_ready   = w_can_accept && req1_valid &&  w_grant_id;
        w_accept     = req0_ready || req1_ready;

        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        opcode_d = opcode_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        zero_d   = zero_q;
        rsp_id_d = rsp_id_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d  = EXEC;
                    last_d   = w_grant_id;
                    id_d     = w_grant_id;
                    opcode_d = w_grant_id ? req1_opcode : req0_opcode;
                    op_d     = w_grant_id ? req1_alu_op : req0_alu_op;
                    a_d      = w_grant_id ? req1_a      : req0_a;
                    b_d      = w_grant_id ? req1_b      : req0_b;
                end
            end
            EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                rsp_id_d = id_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;   // requester 0 wins the first contention
            id_q     <= 1'b0;
            opcode_q <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            rsp_id_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            opcode_q <= opcode_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            rsp_id_q <= rsp_id_d;
        end
    end

    // ALU inputs always come from registers so they never follow live requests.
    assign alu_opcode = opcode_q;
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;

    assign rsp_valid  = (state_q == DONE);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Directed self-checking bench for alu_arbiter. A small ALU
//                model (subtract for alu_op 01, add otherwise) closes the
//                loop; expected responses are hand-computed constants.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int WIDTH = 64;
    localparam logic [10:0] C_ADD_OPC = 11'b10001011000;

    logic             clk = 1'b0;
    logic             reset;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [10:0]      req0_opcode, req1_opcode;
    logic [1:0]       req0_alu_op, req1_alu_op;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [10:0]      alu_opcode;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid, rsp_id, rsp_zero, busy;
    logic [WIDTH-1:0] rsp_result;

    int errors = 0;
    int checks = 0;
    logic prev_rsp = 1'b0;
    logic mon_en   = 1'b0;

    always #5 clk = ~clk;

    // Shared ALU model
    assign alu_result = (alu_op == 2'b01) ? (alu_a - alu_b) : (alu_a + alu_b);
    assign alu_zero   = (alu_result == '0);

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_opcode(req0_opcode),
        .req1_opcode(req1_opcode),
        .req0_alu_op(req0_alu_op),
        .req1_alu_op(req1_alu_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .alu_opcode (alu_opcode),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor
    always @(negedge clk) begin
        if (mon_en) begin
            check("mutex_ready", {63'd0, req0_ready & req1_ready}, 64'd0);
            check("rsp_twice",   {63'd0, prev_rsp & rsp_valid},    64'd0);
            if (rsp_valid)               check("busy_in_done", {63'd0, busy}, 64'd1);
            if (req0_ready | req1_ready) check("busy_in_idle", {63'd0, busy}, 64'd0);
            prev_rsp = rsp_valid;
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0;
        req0_opcode = '0; req1_opcode = '0;
        req0_alu_op = '0; req1_alu_op = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // ---- Reset values (valid high must not produce ready) ----
        #3;
        check("rst_ready0",  {63'd0, req0_ready}, 64'd0);
        check("rst_busy",    {63'd0, busy},       64'd0);
        check("rst_rspv",    {63'd0, rsp_valid},  64'd0);
        check("rst_result",  rsp_result,          64'd0);
        check("rst_alu_a",   alu_a,               64'd0);
        check("rst_alu_opc", {53'd0, alu_opcode}, 64'd0);

        // ---- Single request, add: 5 + 7 = 12, granted on first edge ----
        @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;
        req0_alu_op = 2'b10; req0_opcode = C_ADD_OPC; req0_a = 64'd5; req0_b = 64'd7;
        #1;
        check("t1_ready0", {63'd0, req0_ready}, 64'd1);
        check("t1_ready1", {63'd0, req1_ready}, 64'd0);
        tick();                                   // EXEC
        req0_valid = 1'b0; req0_a = 64'd99;       // live inputs must not leak
        #1;
        check("t1_busy",    {63'd0, busy},       64'd1);
        check("t1_rspv_ex", {63'd0, rsp_valid},  64'd0);
        check("t1_alu_a",   alu_a,               64'd5);
        check("t1_alu_b",   alu_b,               64'd7);
        check("t1_alu_opc", {53'd0, alu_opcode}, {53'd0, C_ADD_OPC});
        check("t1_alu_op",  {62'd0, alu_op},     64'd2);
        tick();                                   // DONE
        check("t1_rspv",   {63'd0, rsp_valid}, 64'd1);
        check("t1_result", rsp_result,         64'd12);
        check("t1_id",     {63'd0, rsp_id},    64'd0);
        check("t1_zero",   {63'd0, rsp_zero},  64'd0);
        tick();                                   // IDLE
        check("t1_rspv_off", {63'd0, rsp_valid}, 64'd0);
        check("t1_idle",     {63'd0, busy},      64'd0);
        check("t1_hold_res", rsp_result,         64'd12);
        check("t1_hold_a",   alu_a,              64'd5);

        // ---- Zero flag: req1 subtract 9 - 9 ----
        req1_valid = 1'b1; req1_alu_op = 2'b01; req1_a = 64'd9; req1_b = 64'd9;
        #1;
        check("t2_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        check("t2_rspv",   {63'd0, rsp_valid}, 64'd1);
        check("t2_result", rsp_result,         64'd0);
        check("t2_zero",   {63'd0, rsp_zero},  64'd1);
        check("t2_id",     {63'd0, rsp_id},    64'd1);
        tick();

        // ---- Reset in EXEC discards the operation ----
        req0_valid = 1'b1; req0_alu_op = 2'b10; req0_a = 64'd3; req0_b = 64'd4;
        #1;
        check("t3_ready0", {63'd0, req0_ready}, 64'd1);
        tick();                                   // EXEC
        req0_valid = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("t3_busy",   {63'd0, busy},      64'd0);
        check("t3_rspv",   {63'd0, rsp_valid}, 64'd0);
        check("t3_alu_a",  alu_a,              64'd0);
        check("t3_alu_op", {62'd0, alu_op},    64'd0);
        check("t3_result", rsp_result,         64'd0);
        check("t3_id",     {63'd0, rsp_id},    64'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("t3_no_rsp1", {63'd0, rsp_valid}, 64'd0);
        tick();
        check("t3_no_rsp2", {63'd0, rsp_valid}, 64'd0);
        // next request served normally: 6 + 1 = 7
        req0_valid = 1'b1; req0_a = 64'd6; req0_b = 64'd1;
        #1;
        check("t3_ready0b", {63'd0, req0_ready}, 64'd1);
        tick();
        req0_valid = 1'b0;
        tick();
        check("t3_rspv_b", {63'd0, rsp_valid}, 64'd1);
        check("t3_res_b",  rsp_result,         64'd7);
        tick();

        // ---- Contention from reset release: grants 0,1,0,1 ----
        @(negedge clk);
        reset = 1'b1;
        req0_valid = 1'b1; req0_alu_op = 2'b10; req0_a = 64'd1;  req0_b = 64'd2;
        req1_valid = 1'b1; req1_alu_op = 2'b10; req1_a = 64'd10; req1_b = 64'd20;
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("t4_ready0", {63'd0, req0_ready}, {63'd0, (k % 2) == 0});
            check("t4_ready1", {63'd0, req1_ready}, {63'd0, (k % 2) == 1});
            tick();                               // EXEC
            check("t4_noready", {63'd0, req0_ready | req1_ready}, 64'd0);
            tick();                               // DONE
            check("t4_rspv",   {63'd0, rsp_valid},  64'd1);
            check("t4_id",     {63'd0, rsp_id},     {63'd0, (k % 2) == 1});
            check("t4_result", rsp_result,          ((k % 2) == 0) ? 64'd3 : 64'd30);
            tick();                               // IDLE
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;

        // ---- Withdrawal while busy; pointer moves only on handshake ----
        req0_valid = 1'b1; req0_a = 64'd4; req0_b = 64'd4;
        #1;
        check("t5_ready0", {63'd0, req0_ready}, 64'd1);
        tick();                                   // EXEC
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        check("t5_r1_busy", {63'd0, req1_ready}, 64'd0);
        tick();                                   // DONE
        req1_valid = 1'b0;
        check("t5_rspv", {63'd0, rsp_valid}, 64'd1);
        check("t5_res",  rsp_result,         64'd8);
        tick();                                   // IDLE
        req0_valid = 1'b1; req0_a = 64'd2; req0_b = 64'd2;
        #1;
        check("t5_ready0b", {63'd0, req0_ready}, 64'd1);
        check("t5_ready1b", {63'd0, req1_ready}, 64'd0);
        tick();
        req0_valid = 1'b0;
        tick();
        check("t5_id_b", {63'd0, rsp_id}, 64'd0);
        tick();
        // last grant was 0, so contention now goes to requester 1
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        check("t5_ptr_r1", {63'd0, req1_ready}, 64'd1);
        check("t5_ptr_r0", {63'd0, req0_ready}, 64'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        check("t5_id_c", {63'd0, rsp_id}, 64'd1);
        tick();
        tick();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand and result width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid, req1_valid  input  1 each  requester N holds a pending operation.
REQ-005 SHALL have ports req0_ready, req1_ready  output  1 each  requester N operation accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_opcode, req1_opcode  input  11 each  instruction opcode field for ALU control.
REQ-007 SHALL have ports req0_alu_op, req1_alu_op  input  2 each  main-decoder ALU op class.
REQ-008 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH each  operands.
REQ-009 SHALL have ports alu_opcode  output  11, alu_op  output  2  drive the shared ALU control decoder.
REQ-010 SHALL have ports alu_a, alu_b  output  WIDTH each  operands to the shared ALU.
REQ-011 SHALL have ports alu_result  input  WIDTH, alu_zero  input  1  combinational ALU outputs.
REQ-012 SHALL have ports rsp_valid  output  1, rsp_id  output  1, rsp_result  output  WIDTH, rsp_zero  output  1  completed operation and owning requester.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL implement states IDLE, EXEC, DONE.
REQ-015 In IDLE, SHALL assert exactly one ready, to the granted requester, only when that requester's valid is high; at most one ready high in any cycle.
REQ-016 Grant: only one valid -> that requester; both valid -> requester not granted last; none -> no ready.
REQ-017 Last-grant pointer SHALL update only on an accepted handshake; reset value points to requester 1, so requester 0 wins the first contention.
REQ-018 On handshake in IDLE, SHALL register opcode, alu_op, a, b and requester id, then transition to EXEC.
REQ-019 In EXEC, alu_opcode/alu_op/alu_a/alu_b SHALL present the registered values; at clock edge SHALL capture alu_result and alu_zero, then go to DONE.
REQ-020 In DONE, rsp_valid SHALL be high for exactly one cycle with captured result, zero and id; next state IDLE.
REQ-021 Latency: handshake in cycle N -> rsp_valid in cycle N+2; new handshake earliest in cycle N+3; throughput one operation per 3 cycles.
REQ-022 Response has no backpressure; requester SHALL sample it in the rsp_valid cycle.
REQ-023 alu_* outputs SHALL hold registered values in IDLE and DONE (no glitching to live request inputs).
REQ-024 alu_op 2'b11 and unlisted opcodes SHALL be passed through unmodified; no error detection in this block.
REQ-025 Requester dropping valid before acceptance SHALL lose nothing and cause no pointer update.
REQ-026 rsp_result/rsp_zero/rsp_id SHALL hold last captured values outside DONE; rsp_valid qualifies them.

Reset
REQ-027 Reset asserted SHALL immediately force state IDLE, req0_ready=req1_ready=0 until deassertion, rsp_valid=0, busy=0, rsp_result=0, rsp_zero=0, rsp_id=0, alu_opcode=0, alu_op=0, alu_a=0, alu_b=0, last-grant pointer=1.
REQ-028 Reset during EXEC or DONE SHALL discard the in-flight operation; no rsp_valid for it after release.
REQ-029 First grant SHALL be possible in first clock edge after reset deassertion.

Verification
REQ-030 Single request: req0 valid, alu_op=2'b10, opcode=11'b10001011000, a=5, b=7, ALU models add -> req0_ready cycle N, rsp_valid cycle N+2, rsp_result=12, rsp_id=0, rsp_zero=0.
REQ-031 Contention: both valid continuously from reset release -> grants 0,1,0,1 at cycles N, N+3, N+6, N+9; rsp_id alternates 0,1,0,1.
REQ-032 Zero flag: req1 valid, alu_op=2'b01, a=b=9, ALU models subtract -> rsp_result=0, rsp_zero=1, rsp_id=1.
REQ-033 Reset mid-op: handshake at N, reset pulsed in N+1 -> no rsp_valid at N+2; all outputs at reset values; next request served normally.
REQ-034 Withdrawal: req1 valid one cycle while busy then dropped, req0 valid after -> req1 never readied, req0 granted, pointer=0 afterwards.
REQ-035 Protocol assertions throughout: req0_ready&req1_ready never both 1; rsp_valid never two consecutive cycles; busy=0 iff IDLE.
